// File: rtl/dmac_pkg.sv
// Shared types and constants for the DDR-to-SRAM DMA engine.
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } d2s_state_t;

  localparam logic [2:0]  MIG_CMD_READ   = 3'b001;
  localparam int unsigned BEAT_ADDR_INC  = 8;
  localparam int unsigned WORDS_PER_BEAT = 4;

endpackage

// File: rtl/dmac_d2s_fifo.sv
// Synchronous FIFO holding returned MIG read beats until they are unpacked into SRAM words.
module dmac_d2s_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dmac_d2s.sv
// DMA engine: reads a block of 128-bit beats from DDR through the MIG and writes it to SRAM
// as consecutive 32-bit words.
module dmac_d2s
  import dmac_pkg::*;
#(
  parameter int unsigned DDR_AW     = 28,
  parameter int unsigned SRAM_AW    = 14,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DDR_AW-1:0]  src_addr,
  input  logic [SRAM_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic [DDR_AW-1:0]  app_addr,
  output logic [2:0]         app_cmd,
  output logic               app_en,
  input  logic               app_rdy,
  input  logic [127:0]       app_rd_data,
  input  logic               app_rd_data_valid,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  d2s_state_t         state_q, state_d;
  logic [DDR_AW-1:0]  addr_q;
  logic [SRAM_AW-1:0] waddr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cmds_q;
  logic [LEN_W-1:0]   beats_q;
  logic [CNT_W-1:0]   inflight_q;
  logic [1:0]         word_q;
  logic               final_q;
  logic               sram_we_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [31:0]        sram_wdata_q;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [127:0]       fifo_rdata;
  logic [OCC_W-1:0]   occupancy;
  logic               accept;
  logic               drain;
  logic               launch;

  dmac_d2s_fifo #(
    .WIDTH (128),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (app_rd_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credit: every outstanding read must have a FIFO slot reserved for its returning beat.
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign app_en    = (state_q == RUN) && (cmds_q < len_q) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept    = app_en && app_rdy;
  assign fifo_push = (state_q == RUN) && app_rd_data_valid;
  assign drain     = (state_q == RUN) && !fifo_empty;
  assign fifo_pop  = drain && (word_q == 2'(WORDS_PER_BEAT - 1));
  assign launch    = (state_q == IDLE) && start && (len != '0);

  assign app_addr   = addr_q;
  assign app_cmd    = MIG_CMD_READ;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (len != '0) ? RUN : FIN;
      end
      RUN: begin
        if (final_q) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      waddr_q      <= '0;
      len_q        <= '0;
      cmds_q       <= '0;
      beats_q      <= '0;
      inflight_q   <= '0;
      word_q       <= '0;
      final_q      <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      sram_we_q <= drain;
      // Flags the final word so RUN leaves in the cycle after that write is visible.
      final_q   <= fifo_pop && (beats_q == len_q - LEN_W'(1));

      if (launch) begin
        addr_q     <= src_addr;
        waddr_q    <= dst_addr;
        len_q      <= len;
        cmds_q     <= '0;
        beats_q    <= '0;
        inflight_q <= '0;
        word_q     <= '0;
      end else begin
        if (accept) begin
          addr_q <= addr_q + DDR_AW'(BEAT_ADDR_INC);
          cmds_q <= cmds_q + 1'b1;
        end

        if (accept && !fifo_push) begin
          inflight_q <= inflight_q + 1'b1;
        end else if (fifo_push && !accept && (inflight_q != '0)) begin
          inflight_q <= inflight_q - 1'b1;
        end

        if (drain) begin
          sram_addr_q  <= waddr_q;
          sram_wdata_q <= fifo_rdata[{word_q, 5'd0} +: 32];
          waddr_q      <= waddr_q + 1'b1;
          word_q       <= word_q + 1'b1;
        end

        if (fifo_pop) beats_q <= beats_q + 1'b1;
      end
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_dmac_d2s.sv
// Self-checking bench for dmac_d2s: MIG read model, SRAM write scoreboard, table-driven transfers.
module tb_dmac_d2s;

  logic         clk;
  logic         reset;
  logic         start;
  logic [27:0]  src_addr;
  logic [13:0]  dst_addr;
  logic [15:0]  len;
  logic         busy;
  logic         done;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         sram_we;
  logic [13:0]  sram_addr;
  logic [31:0]  sram_wdata;

  dmac_d2s dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .len               (len),
    .busy              (busy),
    .done              (done),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .sram_we           (sram_we),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [27:0] src;
    logic [13:0] dst;
    logic [15:0] len;
    int          rdy_mode;   // 0: always ready, 1: toggles every cycle
    int          lat;        // accept-to-data cycles
    int          hold;       // no data before this many cycles after start
    int          restart_at; // nonzero: pulse a foreign start this many cycles in
    logic [7:0]  tag;
    int          max_early;  // accepts allowed before first data returns
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  pend_t       pend_q [$];
  wr_t         exp_wr_q [$];
  logic [27:0] exp_cmd_q [$];
  logic [27:0] cur_src = '0;
  logic [7:0]  cur_tag = '0;
  int          rdy_mode = 0;
  int          lat = 3;
  int          hold_until = 0;
  int          acc_cnt = 0;
  int          early_cnt = 0;
  bit          first_data = 1'b0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_wr_cyc = 0;
  int          wr_total = 0;
  bit          hold_valid = 1'b0;
  logic [27:0] held_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected value %0h, expected none (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] tag, input int unsigned idx);
    return {tag, 24'(idx + 1)};
  endfunction

  function automatic logic [127:0] beat_of(input logic [27:0] a);
    logic [27:0]  d;
    int unsigned  b;
    logic [127:0] r;
    d = a - cur_src;
    b = int'(d >> 3);
    for (int k = 0; k < 4; k++) r[32*k +: 32] = word_of(cur_tag, b * 4 + k);
    return r;
  endfunction

  // MIG model + monitor: sample on the falling edge, drive just after the rising edge.
  initial begin
    app_rdy           = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (app_en && app_rdy) begin
        acc_cnt++;
        if (!first_data) early_cnt++;
        if (exp_cmd_q.size() == 0) flag_fail("unexpected_accept", 64'(app_addr));
        else chk("cmd_addr", 64'(app_addr), 64'(exp_cmd_q.pop_front()));
        pend_q.push_back('{addr: app_addr, due: cyc + lat});
      end
      if (hold_valid && app_en) chk("addr_hold", 64'(app_addr), 64'(held_addr));
      hold_valid = app_en && !app_rdy;
      held_addr  = app_addr;
      if (sram_we) begin
        wr_t e;
        wr_total++;
        last_wr_cyc = cyc;
        if (exp_wr_q.size() == 0) begin
          flag_fail("unexpected_write", {18'h0, sram_addr, sram_wdata});
        end else begin
          e = exp_wr_q.pop_front();
          chk("sram_write", {18'h0, sram_addr, sram_wdata}, {18'h0, e.addr, e.data});
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      app_rdy = (rdy_mode == 0) || ((cyc % 2) == 0);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1 && cyc + 1 >= hold_until) begin
        app_rd_data       = beat_of(pend_q[0].addr);
        app_rd_data_valid = 1'b1;
        void'(pend_q.pop_front());
        first_data = 1'b1;
      end else begin
        app_rd_data_valid = 1'b0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_app_en"}, 64'(app_en), 64'(0));
    chk({tag, "_app_addr"}, 64'(app_addr), 64'(0));
    chk({tag, "_sram_we"}, 64'(sram_we), 64'(0));
    chk({tag, "_sram_addr"}, 64'(sram_addr), 64'(0));
    chk({tag, "_sram_wdata"}, 64'(sram_wdata), 64'(0));
  endtask

  task automatic setup(input vec_t v);
    cur_src    = v.src;
    cur_tag    = v.tag;
    rdy_mode   = v.rdy_mode;
    lat        = v.lat;
    hold_until = cyc + v.hold;
    acc_cnt    = 0;
    early_cnt  = 0;
    first_data = 1'b0;
    done_cnt   = 0;
    for (int b = 0; b < int'(v.len); b++) begin
      exp_cmd_q.push_back(v.src + 28'(8 * b));
      for (int k = 0; k < 4; k++)
        exp_wr_q.push_back('{addr: v.dst + 14'(b * 4 + k), data: word_of(v.tag, b * 4 + k)});
    end
  endtask

  task automatic pulse_start(input vec_t v);
    @(posedge clk);
    #1;
    start    = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = v.len;
    @(negedge clk);
    chk("busy_in_start_cycle", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_transfer(input vec_t v);
    int t;
    setup(v);
    pulse_start(v);
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("first_app_en", 64'(app_en), 64'(1));
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
      if (v.restart_at != 0 && t == v.restart_at) begin
        start    = 1'b1;
        src_addr = 28'h7770;
        dst_addr = 14'h3000;
        len      = 16'd2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cnt == 0) flag_fail("done_timeout", 64'(t));
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("done_after_last_write", 64'(done_cyc - last_wr_cyc), 64'(1));
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("accepts", 64'(acc_cnt), 64'(v.len));
    chk("early_accepts_within_credit", 64'(early_cnt <= v.max_early), 64'(1));
    chk("writes_left", 64'(exp_wr_q.size()), 64'(0));
    exp_wr_q.delete();
    exp_cmd_q.delete();
  endtask

  vec_t vecs [5];

  initial begin
    vec_t v;
    int   t;
    int   w0;

    vecs[0] = '{src: 28'h100, dst: 14'h10, len: 16'd1, rdy_mode: 0, lat: 3, hold: 0,
                restart_at: 0, tag: 8'h00, max_early: 4};
    vecs[1] = '{src: 28'h200, dst: 14'h40, len: 16'd8, rdy_mode: 1, lat: 3, hold: 0,
                restart_at: 0, tag: 8'h01, max_early: 4};
    vecs[2] = '{src: 28'h1000, dst: 14'h100, len: 16'd10, rdy_mode: 0, lat: 2, hold: 20,
                restart_at: 0, tag: 8'h02, max_early: 4};
    vecs[3] = '{src: 28'h2000, dst: 14'h200, len: 16'd6, rdy_mode: 0, lat: 4, hold: 0,
                restart_at: 5, tag: 8'h03, max_early: 4};
    vecs[4] = '{src: 28'hFFFFFF0, dst: 14'h3FFE, len: 16'd3, rdy_mode: 0, lat: 1, hold: 0,
                restart_at: 0, tag: 8'h04, max_early: 4};

    reset    = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    chk("app_cmd", 64'(app_cmd), 64'(3'b001));
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_transfer(vecs[i]);

    // Zero-length request: straight to FIN, no MIG traffic.
    v = '{src: 28'h300, dst: 14'h50, len: 16'd0, rdy_mode: 0, lat: 3, hold: 0,
          restart_at: 0, tag: 8'h06, max_early: 4};
    setup(v);
    w0 = wr_total;
    @(posedge clk);
    #1;
    start = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = v.len;
    @(negedge clk);
    chk("len0_done_start_cycle", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", 64'(done), 64'(1));
    chk("len0_busy_in_fin", 64'(busy), 64'(1));
    chk("len0_app_en", 64'(app_en), 64'(0));
    @(negedge clk);
    chk("len0_done_low", 64'(done), 64'(0));
    chk("len0_busy_low", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("len0_done_pulses", 64'(done_cnt), 64'(1));
    chk("len0_accepts", 64'(acc_cnt), 64'(0));
    chk("len0_writes", 64'(wr_total - w0), 64'(0));

    // Reset after five SRAM writes while beats are still coming back.
    v = '{src: 28'h4000, dst: 14'h300, len: 16'd6, rdy_mode: 0, lat: 3, hold: 0,
          restart_at: 0, tag: 8'h05, max_early: 4};
    setup(v);
    w0 = wr_total;
    pulse_start(v);
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (wr_total - w0 < 5 && t < 500);
    if (t >= 500) flag_fail("reset_test_write_timeout", 64'(wr_total - w0));
    reset = 1'b1;
    exp_wr_q.delete();
    exp_cmd_q.delete();
    w0 = wr_total;
    @(negedge clk);
    check_reset_vals("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    while (pend_q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("writes_after_reset", 64'(wr_total - w0), 64'(0));
    chk("done_after_abort", 64'(done_cnt), 64'(0));
    chk("idle_after_abort", 64'(busy), 64'(0));

    v = '{src: 28'h5000, dst: 14'h20, len: 16'd1, rdy_mode: 0, lat: 3, hold: 0,
          restart_at: 0, tag: 8'h07, max_early: 4};
    run_transfer(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
